mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
Parametrised multiply/divide unit that executes the HI/LO-class ALU operations (MULT, MULTU, DIV, DIVU, MTHI, MTLO) decoded by the ALU decoder. It replaces single-cycle HI/LO handling with a multi-cycle engine: a fixed-latency multiplier and a radix-2 restoring divider. It sits beside the execute-stage ALU, stalls the pipeline through `ready`, and can be cancelled by an exception or branch flush.

Parameters:
WIDTH, 32, operand width; hi/lo are each WIDTH bits
MUL_LAT, 2, multiply latency in cycles (>=1)

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
start  input  1  request operation; accepted only when ready=1
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  input  WIDTH  multiplicand / dividend (rs)
src_b  input  WIDTH  multiplier / divisor (rt)
flush  input  1  cancel the in-flight operation
hilo_we  input  2  [1] write HI, [0] write LO (MTHI/MTLO)
hilo_wdata  input  WIDTH  data for hilo_we
ready  output  1  unit idle, can accept start
done  output  1  one-cycle pulse: hi/lo updated this cycle
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, resetn=0): state IDLE; hi=0, lo=0, ready=1, done=0; all counters and internal registers 0. Reset mid-operation aborts immediately. No done pulse after release.
- States: IDLE, MUL, DIV, FIN.
  - IDLE: ready=1.
  - MUL/DIV: ready=0.
  - FIN: one cycle; done=1, hi/lo loaded with the result, then IDLE.
- Timing: start is accepted in cycle 0, and hi/lo change on the clock edge ending the FIN cycle.
  - MULT/MULTU: MUL cycles 1..MUL_LAT-1, FIN at cycle MUL_LAT. With MUL_LAT=1 the unit goes IDLE->FIN directly.
  - DIV/DIVU with src_b!=0: latched at start. DIV cycles 1..WIDTH (one quotient bit per cycle), FIN at cycle WIDTH+1.
  - DIV/DIVU with src_b=0: FIN at cycle 1, lo={WIDTH{1}}, hi=src_a.
- Multiply arithmetic: full 2*WIDTH product, hi=upper half, lo=lower half. MULT is signed, MULTU is unsigned.
- Divide arithmetic: DIV divides the magnitudes and then corrects signs.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend (truncation toward zero).
  - The most-negative dividend divided by -1 gives lo=most-negative value, hi=0.
- Operands are latched at acceptance. Changes to src_a, src_b or op while busy have no effect.
- start while ready=0 is ignored; it is not queued.
- flush while in MUL/DIV/FIN: next state IDLE, no done pulse, hi/lo keep their prior values.
- flush and start in the same IDLE cycle: flush wins and start is not accepted.
- hilo_we:
  - Honoured only when ready=1. It writes the selected half on that clock edge and is ignored while busy.
  - If hilo_we and start occur in the same cycle, the write happens and the operation still starts. The operation's FIN later overwrites both halves.
- done is never high while ready=1, except in the FIN->IDLE relation above: done is high only in FIN, where ready=0.

Test Plan:
1. WIDTH=32, MUL_LAT=2: MULT src_a=0xFFFFFFFE, src_b=3 -> ready=0 in cycle 1; done in cycle 2 with hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
2. DIVU 100/7 -> ready=0 in cycles 1..33, done in cycle 33 with lo=14, hi=2. Then DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> done in cycle 1 with lo=0xFFFFFFFF, hi=5.
4. Start DIV, assert flush in cycle 10 -> ready=1 in cycle 11, no done pulse, hi/lo hold their pre-start values. A start pulse in cycle 5 (while busy) is ignored.
5. hilo_we=2'b11, hilo_wdata=0x1234 while idle -> hi=lo=0x1234 next cycle. The same write during a DIV -> no change. A write plus a MULT start in the same cycle -> 0x1234 first, then the product at done.
6. Drive resetn low in cycle 15 of a DIV -> hi=lo=0 and ready=1 immediately (asynchronous). After release, no done pulse appears and a fresh DIVU 9/3 completes with lo=3, hi=0.

Source files
------------

// File: rtl/mdu_iter_if.sv
// Handshake and HI/LO bus between the execute stage and the multiply/divide unit.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic [1:0]       hilo_we;
    logic [WIDTH-1:0] hilo_wdata;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush, hilo_we, hilo_wdata,
        input  ready, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush, hilo_we, hilo_wdata,
        output ready, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Fixed-latency multiplier plus radix-2 restoring divider on operand magnitudes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready=1; accepts start and MTHI/MTLO writes
// MUL   | waiting out the multiply latency (down-counter)
// DIV   | one quotient bit per cycle, WIDTH cycles (down-counter)
// FIN   | result presented, done=1 unless flushed, HI/LO load at edge
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    mdu_iter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state;
    state_t           state_nxt;
    logic             ready_c;
    logic             done_c;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             is_div;
    logic             is_signed;
    logic             div_zero;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             op_div;
    logic             op_sgn;
    logic             b_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               take;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Acceptance and operand conditioning at the start handshake.
    // flush in the same cycle as start cancels the request.
    always_comb begin
        accept = (state == S_IDLE) && bus.start && !bus.flush;
        op_div = bus.op[1];
        op_sgn = ~bus.op[0];
        b_zero = (bus.src_b == '0);
        mag_a  = (op_sgn && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
        mag_b  = (op_sgn && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    // The difference is always below the divisor when taken, so WIDTH bits suffice.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        take    = (shifted >= {1'b0, dvs});
        diff    = shifted[WIDTH-1:0] - dvs;
    end

    // Full-width product; sign-extending to 2*WIDTH gives the signed result modulo 2^(2*WIDTH).
    always_comb begin
        ext_a = is_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
        ext_b = is_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
        prod  = ext_a * ext_b;
    end

    // Result selection for the FIN cycle, including divide sign correction.
    // Most-negative / -1 falls out naturally: magnitude 2^(WIDTH-1), no negation.
    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = op_a;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -rem : rem;
                res_lo = neg_q ? -quo : quo;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = 1'b1;
                if (accept) begin
                    if (op_div) begin
                        state_nxt = b_zero ? S_FIN : S_DIV;
                    end else begin
                        state_nxt = (MUL_LAT == 1) ? S_FIN : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (bus.flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done_c    = !bus.flush;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, latency down-counter and divider datapath.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            div_zero  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
        end else if (accept) begin
            cnt       <= op_div ? DIV_LOAD : MUL_LOAD;
            op_a      <= bus.src_a;
            op_b      <= bus.src_b;
            is_div    <= op_div;
            is_signed <= op_sgn;
            div_zero  <= op_div && b_zero;
            neg_q     <= op_sgn && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            neg_r     <= op_sgn && bus.src_a[WIDTH-1];
            quo       <= mag_a;
            rem       <= '0;
            dvs       <= mag_b;
        end else if (state == S_MUL) begin
            cnt <= cnt - CNT_ONE;
        end else if (state == S_DIV) begin
            cnt <= cnt - CNT_ONE;
            rem <= take ? diff : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], take};
        end
    end

    // HI/LO: MTHI/MTLO writes only while idle; a completed operation overwrites both.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == S_FIN) begin
            if (!bus.flush) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (state == S_IDLE) begin
            if (bus.hilo_we[1]) hi_q <= bus.hilo_wdata;
            if (bus.hilo_we[0]) lo_q <= bus.hilo_wdata;
        end
    end

    assign bus.ready = ready_c;
    assign bus.done  = done_c;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32, MUL_LAT=2): timing, arithmetic, flush, MTHI/MTLO, reset.
module tb_mdu_iter;

    localparam int W = 32;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W), .MUL_LAT(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sampling and driving happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start for exactly one cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
        bus.src_a = 32'hDEAD_BEEF;
        bus.src_b = 32'h0BAD_F00D;
        bus.op    = ~op;
    endtask

    task automatic test_reset();
        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.op         = 2'b00;
        bus.src_a      = '0;
        bus.src_b      = '0;
        bus.flush      = 1'b0;
        bus.hilo_we    = 2'b00;
        bus.hilo_wdata = '0;
        repeat (3) tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake ready=%b done=%b required ready=1 done=0", bus.ready, bus.done);
        end
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_hilo hi=%h lo=%h required 0/0", bus.hi, bus.lo);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release ready=%b done=%b required ready=1 done=0", bus.ready, bus.done);
        end
    endtask

    task automatic test_mult();
        logic [1:0]   ops [2]  = '{2'b00, 2'b01};
        logic [W-1:0] ehi [2]  = '{32'hFFFF_FFFF, 32'h0000_0002};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'hFFFF_FFFE, 32'h0000_0003);
            checks++;
            if (bus.ready !== 1'b0 || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL mult%0d_cycle1 ready=%b done=%b required 0/0", i, bus.ready, bus.done);
            end
            tick();
            checks++;
            if (bus.done !== 1'b1 || bus.ready !== 1'b0) begin
                failures++;
                $display("FAIL mult%0d_cycle2 done=%b ready=%b required 1/0", i, bus.done, bus.ready);
            end
            tick();
            checks++;
            if (bus.hi !== ehi[i] || bus.lo !== 32'hFFFF_FFFA || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL mult%0d_result hi=%h lo=%h ready=%b done=%b required hi=%h lo=fffffffa ready=1 done=0",
                         i, bus.hi, bus.lo, bus.ready, bus.done, ehi[i]);
            end
        end
    endtask

    task automatic test_div();
        logic bad;
        // DIVU 100/7: busy through cycles 1..33, done in 33.
        issue(2'b11, 32'd100, 32'd7);
        bad = 1'b0;
        for (int c = 1; c < 33; c++) begin
            if (bus.ready !== 1'b0 || bus.done !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL divu_busy_window unexpected ready/done in cycles 1..32 required ready=0 done=0");
        end
        checks++;
        if (bus.done !== 1'b1 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL divu_cycle33 done=%b ready=%b required 1/0", bus.done, bus.ready);
        end
        tick();
        checks++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            failures++;
            $display("FAIL divu_100_7 lo=%h hi=%h required lo=0000000e hi=00000002", bus.lo, bus.hi);
        end
        // DIV -7/2 = -3 rem -1.
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        for (int c = 1; c < 33; c++) tick();
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL div_neg_cycle33 done=%b required 1", bus.done);
        end
        tick();
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_m7_2 lo=%h hi=%h required lo=fffffffd hi=ffffffff", bus.lo, bus.hi);
        end
    endtask

    task automatic test_div_boundary();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int c = 1; c < 33; c++) tick();
        tick();
        checks++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
            failures++;
            $display("FAIL div_minneg_m1 lo=%h hi=%h required lo=80000000 hi=00000000", bus.lo, bus.hi);
        end
        issue(2'b11, 32'd5, 32'd0);
        checks++;
        if (bus.done !== 1'b1 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL divzero_cycle1 done=%b ready=%b required 1/0", bus.done, bus.ready);
        end
        tick();
        checks++;
        if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd5 || bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL divzero_result lo=%h hi=%h ready=%b required lo=ffffffff hi=00000005 ready=1",
                     bus.lo, bus.hi, bus.ready);
        end
    endtask

    task automatic test_flush();
        logic saw_done;
        saw_done = 1'b0;
        issue(2'b10, 32'd100, 32'd7);
        for (int c = 1; c < 5; c++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        // Cycle 5: start while busy must be ignored.
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.src_a = 32'd1;
        bus.src_b = 32'd1;
        tick();
        bus.start = 1'b0;
        for (int c = 6; c < 10; c++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        bus.flush = 1'b1;
        if (bus.done === 1'b1) saw_done = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready_cycle11 ready=%b required 1", bus.ready);
        end
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1 || bus.ready !== 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL flush_no_done done pulse or busy seen after flush/ignored start required none");
        end
        checks++;
        if (bus.hi !== 32'd5 || bus.lo !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL flush_hilo_hold hi=%h lo=%h required hi=00000005 lo=ffffffff", bus.hi, bus.lo);
        end
        // flush and start together while idle: start must not be accepted.
        bus.flush = 1'b1;
        issue(2'b01, 32'd2, 32'd2);
        bus.flush = 1'b0;
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_start_same_cycle ready=%b required 1", bus.ready);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.hi !== 32'd5) begin
            failures++;
            $display("FAIL flush_start_no_op done=%b hi=%h required done=0 hi=00000005", bus.done, bus.hi);
        end
    endtask

    task automatic test_hilo();
        bit got;
        bus.hilo_we    = 2'b11;
        bus.hilo_wdata = 32'h1234;
        tick();
        bus.hilo_we = 2'b00;
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h1234) begin
            failures++;
            $display("FAIL hilo_idle_write hi=%h lo=%h required 00001234/00001234", bus.hi, bus.lo);
        end
        bus.hilo_we = 2'b01;
        bus.hilo_wdata = 32'h55;
        tick();
        bus.hilo_we = 2'b00;
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h55) begin
            failures++;
            $display("FAIL hilo_lo_only hi=%h lo=%h required 00001234/00000055", bus.hi, bus.lo);
        end
        issue(2'b11, 32'd20, 32'd6);
        bus.hilo_we    = 2'b11;
        bus.hilo_wdata = 32'hABCD;
        tick();
        bus.hilo_we = 2'b00;
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h55) begin
            failures++;
            $display("FAIL hilo_busy_write hi=%h lo=%h required 00001234/00000055", bus.hi, bus.lo);
        end
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (bus.done === 1'b1) got = 1'b1;
            tick();
        end
        checks++;
        if (!got || bus.lo !== 32'd3 || bus.hi !== 32'd2) begin
            failures++;
            $display("FAIL hilo_divu_20_6 done_seen=%b lo=%h hi=%h required done_seen=1 lo=00000003 hi=00000002",
                     got, bus.lo, bus.hi);
        end
        bus.hilo_we    = 2'b11;
        bus.hilo_wdata = 32'h1234;
        issue(2'b00, 32'd3, 32'd4);
        bus.hilo_we = 2'b00;
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h1234 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL hilo_write_with_start hi=%h lo=%h ready=%b required 00001234/00001234 ready=0",
                     bus.hi, bus.lo, bus.ready);
        end
        tick();
        tick();
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'd12) begin
            failures++;
            $display("FAIL hilo_then_product hi=%h lo=%h required 00000000/0000000c", bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        issue(2'b10, 32'd1000, 32'd3);
        for (int c = 1; c < 15; c++) tick();
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset hi=%h lo=%h ready=%b done=%b required 0/0 ready=1 done=0",
                     bus.hi, bus.lo, bus.ready, bus.done);
        end
        #2;
        resetn = 1'b1;
        tick();
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_no_done done pulse seen after reset release required none");
        end
        issue(2'b11, 32'd9, 32'd3);
        saw_done = 1'b0;
        for (int c = 0; c < 40 && !saw_done; c++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (!saw_done || bus.lo !== 32'd3 || bus.hi !== 32'd0) begin
            failures++;
            $display("FAIL reset_fresh_divu done_seen=%b lo=%h hi=%h required done_seen=1 lo=00000003 hi=00000000",
                     saw_done, bus.lo, bus.hi);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_boundary();
        test_flush();
        test_hilo();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
